pll_lock_sequencer: RTL and testbench



---
 rtl/pll_lock_sequencer.sv | 88 ++++++++
 tb/tb_pll_lock_sequencer.sv | 99 +++++++++
 2 files changed

// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer: filters PLL lock, sequences core reset release and the SDRAM power-up wait.
module pll_lock_sequencer #(
   parameter int LOCK_STABLE  = 1024,
   parameter int PWRUP_CYCLES = 25000,
   parameter int LOSS_FILT    = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       pll_locked,
   output logic       core_rst,
   output logic       ready,
   output logic       init_start,
   output logic [7:0] loss_count
);
   localparam int SW = $clog2(LOCK_STABLE) + 1;
   localparam int PW = $clog2(PWRUP_CYCLES) + 1;
   localparam int LW = $clog2(LOSS_FILT) + 1;
   localparam logic [SW-1:0] STAB_MAX = SW'(LOCK_STABLE - 1);
   localparam logic [PW-1:0] PWR_MAX  = PW'(PWRUP_CYCLES - 1);
   localparam logic [LW-1:0] LF_MAX   = LW'(LOSS_FILT - 1);
   typedef enum logic [1:0] {IDLE, STABLE, PWRUP, READY} state_t;
   state_t        state_q, state_d;
   logic [1:0]    sync_q;
   logic [SW-1:0] stab_q, stab_d;
   logic [PW-1:0] pwr_q, pwr_d;
   logic [LW-1:0] lf_q, lf_d;
   logic [7:0]    loss_q, loss_d;
   logic          init_q, init_d;
   logic          locked_s, filt, lost;
   assign locked_s = sync_q[1];
   assign filt     = (state_q == PWRUP) || (state_q == READY);
   assign lost     = filt && !locked_s && (lf_q == LF_MAX);
   always_comb begin
      state_d = state_q;
      stab_d  = stab_q;
      pwr_d   = pwr_q;
      lf_d    = lf_q;
      loss_d  = loss_q;
      case (state_q)
         IDLE: begin
            stab_d = '0;
            pwr_d  = '0;
            lf_d   = '0;
            if (locked_s) state_d = STABLE;
         end
         STABLE: begin
            if (!locked_s) state_d = IDLE;
            else if (stab_q == STAB_MAX) state_d = PWRUP;
            else stab_d = stab_q + 1'b1;
         end
         PWRUP: begin
            if (pwr_q == PWR_MAX) state_d = READY;
            else pwr_d = pwr_q + 1'b1;
         end
         default: ;
      endcase
      // the loss filter overrides any PWRUP progress on the same cycle
      if (filt) lf_d = locked_s ? '0 : lf_q + 1'b1;
      if (lost) begin
         state_d = IDLE;
         loss_d  = (loss_q == 8'hFF) ? loss_q : loss_q + 8'd1;
      end
      init_d = (state_d == READY) && (state_q != READY);
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         sync_q  <= '0;
         stab_q  <= '0;
         pwr_q   <= '0;
         lf_q    <= '0;
         loss_q  <= '0;
         init_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sync_q  <= {sync_q[0], pll_locked};
         stab_q  <= stab_d;
         pwr_q   <= pwr_d;
         lf_q    <= lf_d;
         loss_q  <= loss_d;
         init_q  <= init_d;
      end
   end
   assign core_rst   = (state_q == IDLE) || (state_q == STABLE);
   assign ready      = state_q == READY;
   assign init_start = init_q;
   assign loss_count = loss_q;
endmodule

// File: tb/tb_pll_lock_sequencer.sv
// tb_pll_lock_sequencer: directed scoreboard bench with LOCK_STABLE=4, PWRUP_CYCLES=8, LOSS_FILT=3.
module tb_pll_lock_sequencer;
   logic       clk = 1'b0;
   logic       rst;
   logic       pll_locked;
   logic       core_rst, ready, init_start;
   logic [7:0] loss_count;
   typedef struct {
      string      tag;
      logic [10:0] v;
   } exp_t;
   exp_t sb[$];
   int   passed = 0;
   int   total  = 0;
   int   fails  = 0;
   pll_lock_sequencer #(.LOCK_STABLE(4), .PWRUP_CYCLES(8), .LOSS_FILT(3)) dut (
      .clk       (clk),
      .rst       (rst),
      .pll_locked(pll_locked),
      .core_rst  (core_rst),
      .ready     (ready),
      .init_start(init_start),
      .loss_count(loss_count)
   );
   always #4 clk = ~clk;
   task automatic push(input logic c, input logic r, input logic i, input int l, input string tag);
      exp_t e;
      e.tag = tag;
      e.v   = {c, r, i, 8'(l)};
      sb.push_back(e);
   endtask
   task automatic compare();
      exp_t       e;
      logic [10:0] o;
      e = sb.pop_front();
      o = {core_rst, ready, init_start, loss_count};
      total++;
      assert (o === e.v) passed++;
      else begin
         fails++;
         $error("FAIL %s: core_rst/ready/init_start/loss_count got %b/%b/%b/%0d expected %b/%b/%b/%0d",
                e.tag, o[10], o[9], o[8], o[7:0], e.v[10], e.v[9], e.v[8], e.v[7:0]);
      end
   endtask
   task automatic cyc(input logic p, input logic c, input logic r, input logic i, input int l, input string tag);
      pll_locked = p;
      push(c, r, i, l, tag);
      @(posedge clk);
      #1;
      compare();
   endtask
   task automatic run(input logic p, input int n, input logic c, input logic r, input logic i, input int l,
                      input string tag);
      repeat (n) cyc(p, c, r, i, l, tag);
   endtask
   // lock held high from the next edge E: STABLE at E+2, core_rst falls after E+6, ready after E+14
   task automatic full_seq(input int l, input string tag);
      run(1'b1, 6, 1'b1, 1'b0, 1'b0, l, {tag, "_stable"});
      run(1'b1, 8, 1'b0, 1'b0, 1'b0, l, {tag, "_pwrup"});
      cyc(1'b1, 1'b0, 1'b1, 1'b1, l, {tag, "_init"});
      run(1'b1, 3, 1'b0, 1'b1, 1'b0, l, {tag, "_ready"});
   endtask
   initial begin
      rst        = 1'b1;
      pll_locked = 1'b0;
      run(1'b0, 20, 1'b1, 1'b0, 1'b0, 0, "t1_rst");
      rst = 1'b0;
      run(1'b0, 5, 1'b1, 1'b0, 1'b0, 0, "t1_idle");
      run(1'b1, 3, 1'b1, 1'b0, 1'b0, 0, "t3_stable");
      run(1'b0, 2, 1'b1, 1'b0, 1'b0, 0, "t3_drop");
      full_seq(0, "t2");
      run(1'b0, 2, 1'b0, 1'b1, 1'b0, 0, "t4_glitch");
      run(1'b1, 5, 1'b0, 1'b1, 1'b0, 0, "t4_hold");
      run(1'b0, 4, 1'b0, 1'b1, 1'b0, 0, "t4_filt");
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 1, "t4_loss");
      run(1'b0, 3, 1'b1, 1'b0, 1'b0, 1, "t4_idle");
      full_seq(1, "t4_reseq");
      run(1'b0, 4, 1'b0, 1'b1, 1'b0, 1, "t5_filt");
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 2, "t5_loss");
      for (int k = 3; k <= 300; k++) begin
         run(1'b1, 6, 1'b1, 1'b0, 1'b0, (k - 1 > 255) ? 255 : k - 1, "t5_stable");
         cyc(1'b1, 1'b0, 1'b0, 1'b0, (k - 1 > 255) ? 255 : k - 1, "t5_pwrup");
         run(1'b0, 4, 1'b0, 1'b0, 1'b0, (k - 1 > 255) ? 255 : k - 1, "t5_filt");
         cyc(1'b0, 1'b1, 1'b0, 1'b0, (k > 255) ? 255 : k, "t5_sat");
      end
      run(1'b1, 6, 1'b1, 1'b0, 1'b0, 255, "t6_stable");
      run(1'b1, 3, 1'b0, 1'b0, 1'b0, 255, "t6_pwrup");
      #2;
      push(1'b1, 1'b0, 1'b0, 0, "t6_async");
      rst = 1'b1;
      #1;
      compare();
      run(1'b1, 2, 1'b1, 1'b0, 1'b0, 0, "t6_hold");
      rst = 1'b0;
      full_seq(0, "t6_reseq");
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
